// File: rtl/sr_frame_rx.sv
// sr_frame_rx: frame receiver fed by a 4-bit serial shift-register window.
// Hunts for SYNC_PAT on the window, collects DATA_BITS bits MSB-first from
// win[0], then offers the word on a valid/ready handshake and counts accepted
// frames.
// Optional feature macro: PARITY_CHECK_EN adds a trailing even-parity bit per
// frame and a one-cycle parity_err pulse on failure.
module sr_frame_rx #(
  parameter logic [3:0]  SYNC_PAT  = 4'b1011,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           win,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic                 parity_err
);

  localparam int unsigned BC_W = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    S_HUNT,
    S_COLLECT,
`ifdef PARITY_CHECK_EN
    S_PARITY,
`endif
    S_DONE
  } state_t;

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [BC_W-1:0]      bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] data_out_n;
  logic                 data_valid_n;
  logic                 busy_n;
  logic [CNT_W-1:0]     frame_cnt_n;
  logic                 parity_err_n;
  logic                 parity_err_q;

  // State and registered outputs; synchronous reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_HUNT;
      shreg        <= '0;
      bit_cnt      <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      busy         <= 1'b0;
      frame_cnt    <= '0;
      parity_err_q <= 1'b0;
    end else begin
      state        <= state_n;
      shreg        <= shreg_n;
      bit_cnt      <= bit_cnt_n;
      data_out     <= data_out_n;
      data_valid   <= data_valid_n;
      busy         <= busy_n;
      frame_cnt    <= frame_cnt_n;
      parity_err_q <= parity_err_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    data_out_n   = data_out;
    data_valid_n = data_valid;
    frame_cnt_n  = frame_cnt;
    parity_err_n = 1'b0;

    case (state)
      S_HUNT: begin
        if (win == SYNC_PAT) begin
          state_n   = S_COLLECT;
          bit_cnt_n = '0;
        end
      end

      // Sync patterns inside the payload are data, not a resync.
      S_COLLECT: begin
        shreg_n   = {shreg[DATA_BITS-2:0], win[0]};
        bit_cnt_n = bit_cnt + BC_W'(1);
        if (bit_cnt == BC_W'(DATA_BITS - 1)) begin
`ifdef PARITY_CHECK_EN
          state_n = S_PARITY;
`else
          data_out_n   = shreg_n;
          data_valid_n = 1'b1;
          state_n      = S_DONE;
`endif
        end
      end

`ifdef PARITY_CHECK_EN
      // Even parity over payload plus the trailing bit.
      S_PARITY: begin
        if ((^{shreg, win[0]}) == 1'b0) begin
          data_out_n   = shreg;
          data_valid_n = 1'b1;
          state_n      = S_DONE;
        end else begin
          parity_err_n = 1'b1;
          state_n      = S_HUNT;
        end
      end
`endif

      // Hold the word until accepted; serial bits here are dropped.
      S_DONE: begin
        if (data_valid && data_ready) begin
          data_valid_n = 1'b0;
          frame_cnt_n  = frame_cnt + CNT_W'(1);
          state_n      = S_HUNT;
        end
      end

      default: state_n = S_HUNT;
    endcase

    busy_n = (state_n != S_HUNT);
  end

`ifdef PARITY_CHECK_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
